// File: rtl/instr_dispatch_ctrl.sv
// rtl/instr_dispatch_ctrl.sv - fetch/decode/dispatch sequencer with per-unit clear, select and done watchdog
module instr_dispatch_ctrl #(
    parameter int              PC_W     = 8,
    parameter int              TIMEOUT  = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_data,
    output logic [15:0]     ir,
    output logic [2:0]      unit_clr,
    output logic [2:0]      unit_sel,
    input  logic [2:0]      unit_done,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            halted,
    output logic            fault
);

    localparam int              WD_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LATCH, S_DECODE, S_EXEC, S_ADVANCE, S_HALTED, S_FAULT
    } state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;
    logic [WD_W-1:0] wd_q, wd_d;

    logic [3:0] opc;
    logic [2:0] unit_oh;
    logic       is_nop, is_halt;

    assign opc = ir_q[15:12];

    // One-hot unit for the latched opcode; zero for NOP and HALT.
    always_comb begin
        unit_oh = 3'b000;
        is_nop  = (opc == 4'h0);
        is_halt = (opc == 4'h8);
        if (opc >= 4'h1 && opc <= 4'h3)      unit_oh = 3'b010;
        else if (opc >= 4'h4 && opc <= 4'h7) unit_oh = 3'b100;
        else if (opc >= 4'h9)                unit_oh = 3'b001;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= 16'h0000;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            wd_q    <= wd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        wd_d    = wd_q;
        case (state_q)
            S_IDLE:   if (run) state_d = S_FETCH;
            S_FETCH:  state_d = S_LATCH;
            S_LATCH: begin
                ir_d    = imem_data;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_nop)       state_d = S_ADVANCE;
                else if (is_halt) state_d = S_HALTED;
                else begin
                    wd_d    = '0;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // Done from the selected unit beats a watchdog expiring in the same cycle.
                if ((unit_done & unit_oh) != 3'b000) state_d = S_ADVANCE;
                else if (wd_q == WD_LAST)            state_d = S_FAULT;
                else                                 wd_d = wd_q + 1'b1;
            end
            S_ADVANCE: begin
                pc_d    = pc_q + 1'b1;
                state_d = run ? S_FETCH : S_IDLE;
            end
            S_HALTED: state_d = S_HALTED;
            S_FAULT:  state_d = S_FAULT;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        unit_clr = 3'b000;
        unit_sel = 3'b000;
        busy     = 1'b0;
        halted   = 1'b0;
        fault    = 1'b0;
        case (state_q)
            S_FETCH, S_LATCH, S_ADVANCE: busy = 1'b1;
            S_DECODE: begin
                busy     = 1'b1;
                unit_clr = unit_oh;
            end
            S_EXEC: begin
                busy     = 1'b1;
                unit_sel = unit_oh;
            end
            S_HALTED: halted = 1'b1;
            S_FAULT: begin
                fault    = 1'b1;
                unit_clr = 3'b111;
            end
            default: ;
        endcase
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign ir        = ir_q;

endmodule

// File: tb/tb_instr_dispatch_ctrl.sv
// tb/tb_instr_dispatch_ctrl.sv - directed self-checking bench for instr_dispatch_ctrl
module tb_instr_dispatch_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem [256];

    logic        rst = 1'b1, run = 1'b0;
    logic [7:0]  imem_addr, pc;
    logic [15:0] imem_data, ir;
    logic [2:0]  unit_clr, unit_sel;
    logic [2:0]  unit_done = 3'b000;
    logic        busy, halted, fault;

    logic        w_rst = 1'b1, w_run = 1'b0;
    logic [7:0]  w_imem_addr, w_pc;
    logic [15:0] w_imem_data, w_ir;
    logic [2:0]  w_unit_clr, w_unit_sel;
    logic [2:0]  w_unit_done = 3'b000;
    logic        w_busy, w_halted, w_fault;

    int checks = 0;
    int errors = 0;
    int sel_n, clr_n;

    instr_dispatch_ctrl #(.PC_W(8), .TIMEOUT(32), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst(rst), .run(run), .imem_addr(imem_addr), .imem_data(imem_data),
        .ir(ir), .unit_clr(unit_clr), .unit_sel(unit_sel), .unit_done(unit_done),
        .pc(pc), .busy(busy), .halted(halted), .fault(fault)
    );

    instr_dispatch_ctrl #(.PC_W(8), .TIMEOUT(32), .RESET_PC(8'hFF)) dut_wrap (
        .clk(clk), .rst(w_rst), .run(w_run), .imem_addr(w_imem_addr), .imem_data(w_imem_data),
        .ir(w_ir), .unit_clr(w_unit_clr), .unit_sel(w_unit_sel), .unit_done(w_unit_done),
        .pc(w_pc), .busy(w_busy), .halted(w_halted), .fault(w_fault)
    );

    always_ff @(posedge clk) begin
        imem_data   <= mem[imem_addr];
        w_imem_data <= mem[w_imem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run = 1'b0;
        unit_done = 3'b000;
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pc"},   {24'd0, pc}, 32'h0);
        chk({tag, "_ir"},   {16'd0, ir}, 32'h0);
        chk({tag, "_clr"},  {29'd0, unit_clr}, 32'h0);
        chk({tag, "_sel"},  {29'd0, unit_sel}, 32'h0);
        chk({tag, "_stat"}, {29'd0, busy, halted, fault}, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

        // 1: NOP then HALT
        mem[0] = 16'h0000; mem[1] = 16'h8000;
        do_reset();
        chk_reset("t1_reset");
        chk("t1_addr", {24'd0, imem_addr}, 32'h0);
        run = 1'b1;
        tick(); chk("t1_fetch_busy", {31'd0, busy}, 32'h1);
        tick(); tick(); tick();
        chk("t1_adv_pc", {24'd0, pc}, 32'h0);
        tick(); chk("t1_pc1", {24'd0, pc}, 32'h1);
        tick(); tick(); tick();
        chk("t1_halted", {29'd0, busy, halted, fault}, 32'h2);
        for (int c = 0; c < 10; c++) tick();
        chk("t1_halt_pc", {24'd0, pc}, 32'h1);
        chk("t1_halt_ir", {16'd0, ir}, 32'h8000);
        chk("t1_halt_stat", {26'd0, unit_sel, busy, halted, fault}, 32'h2);

        // 2: ALU dispatch, done in 10th EXEC cycle
        mem[0] = 16'h9042; mem[1] = 16'h8000;
        do_reset();
        run = 1'b1;
        tick(); tick(); tick();
        chk("t2_ir", {16'd0, ir}, 32'h9042);
        chk("t2_clr", {29'd0, unit_clr}, 32'h1);
        sel_n = 0; clr_n = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (unit_sel == 3'b001) sel_n++;
            if (unit_clr != 3'b000) clr_n++;
            if (c == 10) unit_done = 3'b001;
        end
        tick(); unit_done = 3'b000;
        chk("t2_sel_cycles", sel_n, 10);
        chk("t2_clr_exec", clr_n, 0);
        chk("t2_adv", {21'd0, unit_sel, pc}, 32'h0);
        tick(); chk("t2_pc1", {24'd0, pc}, 32'h1);

        // 3: watchdog fault on MOV
        mem[0] = 16'h2000;
        do_reset();
        run = 1'b1;
        tick(); tick(); tick();
        chk("t3_clr", {29'd0, unit_clr}, 32'h2);
        sel_n = 0;
        for (int c = 1; c <= 32; c++) begin
            tick();
            if (unit_sel == 3'b010) sel_n++;
        end
        chk("t3_sel_cycles", sel_n, 32);
        tick();
        chk("t3_fault", {29'd0, busy, halted, fault}, 32'h1);
        chk("t3_fault_sel_clr", {26'd0, unit_sel, unit_clr}, 32'h07);
        chk("t3_fault_pc_ir", {8'd0, pc, ir}, 32'h00002000);
        for (int c = 0; c < 5; c++) tick();
        chk("t3_fault_hold", {26'd0, unit_clr, busy, halted, fault}, 32'h39);
        do_reset();
        chk_reset("t3_reset");

        // 4a: foreign done pulses are ignored
        mem[0] = 16'h9000; mem[1] = 16'h8000;
        do_reset();
        run = 1'b1;
        tick(); tick(); tick();
        sel_n = 0;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (unit_sel == 3'b001) sel_n++;
            unit_done = (c == 7) ? 3'b001 : (c[0] ? 3'b010 : 3'b100);
        end
        chk("t4_sel_cycles", sel_n, 7);
        tick(); unit_done = 3'b000;
        chk("t4_adv_pc", {24'd0, pc}, 32'h0);
        tick();
        chk("t4_pc1", {24'd0, pc}, 32'h1);
        chk("t4_nofault", {31'd0, fault}, 32'h0);

        // 4b: done in the exact timeout cycle
        do_reset();
        run = 1'b1;
        tick(); tick(); tick();
        sel_n = 0;
        for (int c = 1; c <= 32; c++) begin
            tick();
            if (unit_sel == 3'b001) sel_n++;
            if (c == 32) unit_done = 3'b001;
        end
        tick(); unit_done = 3'b000;
        chk("t4b_sel_cycles", sel_n, 32);
        chk("t4b_adv", {26'd0, unit_sel, busy, halted, fault}, 32'h4);
        tick();
        chk("t4b_pc1", {24'd0, pc}, 32'h1);

        // 6: reset mid-EXEC at pc 1
        mem[0] = 16'h0000; mem[1] = 16'h9000;
        do_reset();
        run = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        tick(); tick(); tick();
        chk("t6_dec_pc", {24'd0, pc}, 32'h1);
        tick(); tick();
        chk("t6_exec_sel", {29'd0, unit_sel}, 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset("t6_reset");
        tick();
        chk("t6_refetch", {23'd0, busy, imem_addr}, 32'h100);
        tick(); tick();
        chk("t6_redecode", {13'd0, unit_clr, ir}, 32'h00000000);

        // 5: PC wrap 255 -> 0 and stop on run drop
        mem[255] = 16'h0000; mem[0] = 16'h0000;
        w_rst = 1'b1;
        tick();
        w_rst = 1'b0;
        chk("t5_reset_pc", {16'd0, w_pc, w_imem_addr}, 32'hFFFF);
        w_run = 1'b1;
        tick(); tick();
        w_run = 1'b0;
        tick(); tick();
        chk("t5_adv", {23'd0, w_busy, w_pc}, 32'h1FF);
        tick();
        chk("t5_idle", {23'd0, w_busy, w_pc}, 32'h000);
        for (int c = 0; c < 6; c++) tick();
        chk("t5_stopped", {23'd0, w_busy, w_pc}, 32'h000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
